// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: state codes and handshake constants shared by the divider sequencer.
package div_ctrl_pkg;
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_t;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic [31:0] ZeroWord   = 32'h0;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift, trial subtract, quotient bit).
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [2*DATA_W:0] work,
   input  logic [DATA_W-1:0] dvsr,
   output logic [2*DATA_W:0] work_nxt
);
   logic [DATA_W:0] diff;
   // The partial remainder stays below 2*dvsr, so diff's MSB is exactly the borrow.
   always_comb begin
      diff = work[2*DATA_W-1:DATA_W-1] - {1'b0, dvsr};
      work_nxt = diff[DATA_W] ? work << 1 : {diff, work[DATA_W-2:0], 1'b1};
   end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in EX.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                stallreq_o
);
   div_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic [2*DATA_W:0]   work, work_nxt;
   logic [DATA_W-1:0]   dvsr, mag1, mag2, quo, rem;
   logic                neg_q, neg_r, req;
   always_comb begin
      req = start_i == DivStart && !annul_i;
      mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
      mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
      quo = neg_q ? -work[DATA_W-1:0] : work[DATA_W-1:0];
      rem = neg_r ? -work[2*DATA_W-1:DATA_W] : work[2*DATA_W-1:DATA_W];
      stallreq_o = (state == DivFree && req) || state == DivByZero || state == DivOn;
   end
   div_step #(.DATA_W(DATA_W)) u_step (.work(work), .dvsr(dvsr), .work_nxt(work_nxt));
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DivFree;
         cnt      <= '0;
         work     <= '0;
         dvsr     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= DivResultNotReady;
      end else begin
         case (state)
            DivFree: begin
               result_o <= '0;
               ready_o  <= DivResultNotReady;
               if (req && opdata2_i == '0) state <= DivByZero;
               else if (req) begin
                  state <= DivOn;
                  cnt   <= '0;
                  dvsr  <= mag2;
                  work  <= {{(DATA_W+1){1'b0}}, mag1};
                  neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                  neg_r <= signed_div_i & opdata1_i[DATA_W-1];
               end
            end
            DivByZero: begin
               state    <= DivEnd;
               result_o <= '0;
               ready_o  <= DivResultReady;
            end
            DivOn: begin
               if (annul_i) begin
                  state    <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end else if (cnt != CNT_W'(DATA_W)) begin
                  work <= work_nxt;
                  cnt  <= cnt + 1'b1;
               end else begin
                  state    <= DivEnd;
                  result_o <= {rem, quo};
                  ready_o  <= DivResultReady;
               end
            end
            DivEnd: begin
               // Restart only after EX releases start for a cycle.
               if (start_i == DivStop) begin
                  state    <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized scoreboard bench for div_ctrl against an integer-arithmetic model.
module tb_div_ctrl;
   logic        clk = 1'b0;
   logic        rst, start_i, annul_i, signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic [63:0] result_o;
   logic        ready_o, stallreq_o;
   int          checks = 0, errors = 0, cyc = 0;
   logic        rdy_q = 1'b0;
   typedef struct {
      logic [63:0] res;
      int          due;
   } exp_t;
   exp_t sb[$];
   div_ctrl dut (
      .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
      .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   // Truncating division on sign- or zero-extended 64-bit values, truncated back to 32 bits.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
      longint sa, sd, q, r;
      if (b == 0) return 64'h0;
      sa = sg ? longint'($signed(a)) : longint'(a);
      sd = sg ? longint'($signed(b)) : longint'(b);
      q = sa / sd;
      r = sa % sd;
      return {r[31:0], q[31:0]};
   endfunction
   always @(negedge clk) begin
      exp_t e;
      if (ready_o && !rdy_q) begin
         if (sb.size() == 0) chk("unexpected_ready", 1'b1, 1'b0);
         else begin
            e = sb.pop_front();
            chk("result", result_o, e.res);
            chk("ready_cycle", cyc, e.due);
         end
      end
      rdy_q = ready_o;
   end
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
      logic [63:0] exp;
      int t, st;
      exp = model(a, b, sg);
      opdata1_i = a;
      opdata2_i = b;
      signed_div_i = sg;
      start_i = 1'b1;
      sb.push_back('{exp, cyc + (b == 0 ? 2 : 34)});
      t = 0;
      st = 0;
      #1;
      while (!ready_o && t < 100) begin
         if (stallreq_o) st++;
         @(negedge clk);
         #1;
         t++;
         opdata1_i = $urandom;
         opdata2_i = $urandom;
         signed_div_i = 1'($urandom);
      end
      chk("timeout", t < 100, 1'b1);
      chk("stall_cycles", st, b == 0 ? 2 : 34);
      chk("stall_at_ready", stallreq_o, 1'b0);
      repeat ($urandom_range(0, 2)) begin
         annul_i = 1'($urandom);
         @(negedge clk);
         #1;
         chk("end_ready_hold", ready_o, 1'b1);
         chk("end_result_hold", result_o, exp);
         chk("end_stall", stallreq_o, 1'b0);
      end
      annul_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      #1;
      chk("drop_ready", ready_o, 1'b0);
      chk("drop_result", result_o, 64'h0);
      chk("drop_stall", stallreq_o, 1'b0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      logic [31:0] a, b;
      int seen;
      rst = 1'b1;
      start_i = 1'b0;
      annul_i = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ready", ready_o, 1'b0);
      chk("reset_result", result_o, 64'h0);
      chk("reset_stall", stallreq_o, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("idle_no_ready", ready_o, 1'b0);
      run_div(32'd100, 32'd7, 1'b0);
      run_div(32'hFFFFFFF9, 32'd2, 1'b1);
      run_div(32'hFFFFFFF9, 32'd2, 1'b0);
      run_div(32'd5, 32'd0, 1'b0);
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b1);
      run_div(32'd5, 32'd9, 1'b0);
      run_div(32'd0, 32'd123, 1'b1);
      run_div(32'd7, 32'hFFFFFFF7, 1'b1);
      // Annul in the middle of a divide: nothing may complete.
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      repeat (10) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      #1;
      chk("annul_ready", ready_o, 1'b0);
      chk("annul_result", result_o, 64'h0);
      chk("annul_stall", stallreq_o, 1'b0);
      start_i = 1'b0;
      annul_i = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (ready_o || stallreq_o) seen++;
      end
      chk("annul_quiet", seen, 0);
      // Reset in the middle of a divide.
      opdata1_i = 32'd999;
      opdata2_i = 32'd10;
      start_i = 1'b1;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_ready", ready_o, 1'b0);
      chk("midrst_result", result_o, 64'h0);
      chk("midrst_stall", stallreq_o, 1'b0);
      rst = 1'b0;
      run_div(32'd999, 32'd10, 1'b0);
      repeat (16) begin
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = 32'hFFFFFFFF;
            3: b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         run_div(a, b, 1'($urandom));
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
